sd_wb_master_arb: RTL and testbench

- Two-port Wishbone master arbiter for the SD DMA path.
- Shares the single external Wishbone master bus between requester 0 (RX FIFO filler, memory writes) and requester 1 (TX FIFO filler, memory reads).
- Sits between the filler modules and the system bus.
- Grants whole Wishbone cycles: a grant is held for as long as the owner keeps its cyc asserted.

---
 rtl/sd_wb_master_arb.sv | 159 +++++++++++++++
 tb/tb_sd_wb_master_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_wb_master_arb.sv
// Two-port Wishbone master arbiter: grants whole bus cycles to the RX or TX FIFO filler.
// Optional SD_WB_ARB_TIMEOUT_EN adds an ack watchdog that errors and aborts a stalled cycle.
module sd_wb_master_arb #(
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 256,
  parameter int CNT_W    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic [2:0]  m_wb_cti_o,
  output logic [1:0]  m_wb_bte_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  output logic [1:0]  grant_o
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  if ((1 << CNT_W) <= TIMEOUT) begin : g_bad_cnt_w
    $error("CNT_W too narrow to hold TIMEOUT");
  end

  logic [1:0] r_state;
  logic       r_last;
  logic       w_own0;
  logic       w_own1;
  logic       w_owner_cyc;
  logic       w_pick1;
  logic       w_cyc;
  logic       w_stb;
  logic       w_abort;
  logic       w_to;

  assign w_own0      = (r_state == ST_OWN0);
  assign w_own1      = (r_state == ST_OWN1);
  assign w_owner_cyc = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
  assign grant_o     = r_state;

  // Round-robin breaks a tie against whoever was granted last.
  always_comb begin
    if (ARB_MODE == 1) w_pick1 = m1_cyc_i & ~m0_cyc_i;
    else               w_pick1 = m1_cyc_i & (~m0_cyc_i | ~r_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_cyc_i | m1_cyc_i) begin
            r_state <= w_pick1 ? ST_OWN1 : ST_OWN0;
            r_last  <= w_pick1;
          end
        end
        default: begin
          if (!w_owner_cyc) r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SD_WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;

  assign w_abort = r_abort;
  assign w_to    = (w_own0 | w_own1) & ~r_abort & (r_cnt == CNT_W'(TIMEOUT));

  // Once aborted the counter freezes; the owner must drop cyc to leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else if (!r_abort) begin
      if (w_to)                            r_abort <= 1'b1;
      else if (m_wb_ack_i)                 r_cnt   <= '0;
      else if (m_wb_stb_o && !m_wb_err_i)  r_cnt   <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_abort = 1'b0;
  assign w_to    = 1'b0;
`endif

  always_comb begin
    w_cyc      = 1'b0;
    w_stb      = 1'b0;
    m_wb_we_o  = 1'b0;
    m_wb_adr_o = '0;
    m_wb_dat_o = '0;
    m_wb_cti_o = '0;
    m_wb_bte_o = '0;
    case (r_state)
      ST_OWN0: begin
        w_cyc      = m0_cyc_i;
        w_stb      = m0_stb_i;
        m_wb_we_o  = m0_we_i;
        m_wb_adr_o = m0_adr_i;
        m_wb_dat_o = m0_dat_i;
        m_wb_cti_o = m0_cti_i;
        m_wb_bte_o = m0_bte_i;
      end
      ST_OWN1: begin
        w_cyc      = m1_cyc_i;
        w_stb      = m1_stb_i;
        m_wb_we_o  = m1_we_i;
        m_wb_adr_o = m1_adr_i;
        m_wb_dat_o = m1_dat_i;
        m_wb_cti_o = m1_cti_i;
        m_wb_bte_o = m1_bte_i;
      end
      default: ;
    endcase
  end

  assign m_wb_cyc_o = w_cyc & ~w_abort;
  assign m_wb_stb_o = w_stb & ~w_abort;

  assign m0_ack_o = w_own0 & m_wb_ack_i & ~w_abort;
  assign m1_ack_o = w_own1 & m_wb_ack_i & ~w_abort;
  assign m0_err_o = w_own0 & ((m_wb_err_i & ~w_abort) | w_to);
  assign m1_err_o = w_own1 & ((m_wb_err_i & ~w_abort) | w_to);
  assign m0_dat_o = w_own0 ? m_wb_dat_i : 32'h0;
  assign m1_dat_o = w_own1 ? m_wb_dat_i : 32'h0;

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// Scoreboard bench for sd_wb_master_arb: a round-robin and a fixed-priority instance share stimulus.
module tb_sd_wb_master_arb;

  typedef struct packed {
    logic [1:0]  grant;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack0, err0;
    logic [31:0] rdat0;
    logic        ack1, err1;
    logic [31:0] rdat1;
  } obs_t;

  typedef struct {
    int   id;
    bit   dut;
    obs_t exp;
  } chk_t;

  logic        clk, rst_n;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, wb_dat;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, wb_ack, wb_err;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;

  logic [1:0]  rr_grant, fp_grant;
  logic        rr_cyc, rr_stb, rr_we, fp_cyc, fp_stb, fp_we;
  logic [31:0] rr_adr, rr_wdat, fp_adr, fp_wdat;
  logic [2:0]  rr_cti, fp_cti;
  logic [1:0]  rr_bte, fp_bte;
  logic        rr_ack0, rr_err0, rr_ack1, rr_err1, fp_ack0, fp_err0, fp_ack1, fp_err1;
  logic [31:0] rr_rdat0, rr_rdat1, fp_rdat0, fp_rdat1;

  obs_t rr_obs, fp_obs;
  assign rr_obs = {rr_grant, rr_cyc, rr_stb, rr_we, rr_adr, rr_wdat, rr_cti, rr_bte,
                   rr_ack0, rr_err0, rr_rdat0, rr_ack1, rr_err1, rr_rdat1};
  assign fp_obs = {fp_grant, fp_cyc, fp_stb, fp_we, fp_adr, fp_wdat, fp_cti, fp_bte,
                   fp_ack0, fp_err0, fp_rdat0, fp_ack1, fp_err1, fp_rdat1};

  sd_wb_master_arb #(.ARB_MODE(0), .TIMEOUT(8), .CNT_W(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_ack_o(rr_ack0), .m0_err_o(rr_err0), .m0_dat_o(rr_rdat0),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_ack_o(rr_ack1), .m1_err_o(rr_err1), .m1_dat_o(rr_rdat1),
    .m_wb_adr_o(rr_adr), .m_wb_dat_o(rr_wdat), .m_wb_we_o(rr_we), .m_wb_cyc_o(rr_cyc),
    .m_wb_stb_o(rr_stb), .m_wb_cti_o(rr_cti), .m_wb_bte_o(rr_bte),
    .m_wb_dat_i(wb_dat), .m_wb_ack_i(wb_ack), .m_wb_err_i(wb_err), .grant_o(rr_grant)
  );

  sd_wb_master_arb #(.ARB_MODE(1), .TIMEOUT(8), .CNT_W(4)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_ack_o(fp_ack0), .m0_err_o(fp_err0), .m0_dat_o(fp_rdat0),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_ack_o(fp_ack1), .m1_err_o(fp_err1), .m1_dat_o(fp_rdat1),
    .m_wb_adr_o(fp_adr), .m_wb_dat_o(fp_wdat), .m_wb_we_o(fp_we), .m_wb_cyc_o(fp_cyc),
    .m_wb_stb_o(fp_stb), .m_wb_cti_o(fp_cti), .m_wb_bte_o(fp_bte),
    .m_wb_dat_i(wb_dat), .m_wb_ack_i(wb_ack), .m_wb_err_i(wb_err), .grant_o(fp_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  chk_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_push = 0;
  event sample_ev;

  // Expected outputs given the intended owner (0 idle, 1 = m0, 2 = m1) and current stimulus.
  function automatic obs_t mk(input int own, input bit abort, input bit to_err);
    obs_t o;
    o = '0;
    if (own == 1) begin
      o.grant = 2'b01; o.cyc = m0_cyc & ~abort; o.stb = m0_stb & ~abort; o.we = m0_we;
      o.adr = m0_adr; o.wdat = m0_dat; o.cti = m0_cti; o.bte = m0_bte;
      o.ack0 = wb_ack & ~abort; o.err0 = (wb_err & ~abort) | to_err; o.rdat0 = wb_dat;
    end else if (own == 2) begin
      o.grant = 2'b10; o.cyc = m1_cyc & ~abort; o.stb = m1_stb & ~abort; o.we = m1_we;
      o.adr = m1_adr; o.wdat = m1_dat; o.cti = m1_cti; o.bte = m1_bte;
      o.ack1 = wb_ack & ~abort; o.err1 = (wb_err & ~abort) | to_err; o.rdat1 = wb_dat;
    end
    return o;
  endfunction

  task automatic push(input bit dut, input int own, input bit abort, input bit to_err);
    chk_t c;
    c.id  = n_push;
    c.dut = dut;
    c.exp = mk(own, abort, to_err);
    n_push++;
    q.push_back(c);
  endtask

  task automatic push2(input int own_rr, input int own_fp);
    push(1'b0, own_rr, 1'b0, 1'b0);
    push(1'b1, own_fp, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk_t c;
    obs_t got;
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0) begin
        c   = q.pop_front();
        got = c.dut ? fp_obs : rr_obs;
        n_vec++;
        if (got !== c.exp) begin
          n_miss++;
          $display("FAIL vec%0d %s: got %h want %h", c.id, c.dut ? "fixed" : "rr", got, c.exp);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    m0_adr = 32'h1000_0040; m0_dat = 32'h0A0A_0001; m0_we = 1'b1;
    m0_cti = 3'b010; m0_bte = 2'b01; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h2000_0080; m1_dat = 32'hB1B1_0002; m1_we = 1'b0;
    m1_cti = 3'b111; m1_bte = 2'b10; m1_cyc = 1'b0; m1_stb = 1'b0;
    wb_dat = 32'h0; wb_ack = 1'b0; wb_err = 1'b0;

    // Reset holds the bus idle against a pending request, even across clock edges.
    #2; push2(0, 0);
    step(); push2(0, 0);
    step(); rst_n = 1'b1; push2(0, 0);
    step(); push2(1, 1);
    // Ack arriving as the owner drops cyc is still delivered.
    step(); wb_ack = 1'b1; wb_dat = 32'h5151_AAAA; m0_cyc = 1'b0; m0_stb = 1'b0; push2(1, 1);
    step(); wb_ack = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; push2(0, 0);
    step(); push2(1, 1);

    // Asynchronous reset mid-cycle, no clock edge.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1; push2(0, 0); ->sample_ev;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); push2(0, 0);
    step(); rst_n = 1'b1; push2(0, 0);

    // Simultaneous request after reset: m0 first in both modes; m1 waits unacked.
    step(); wb_ack = 1'b1; wb_dat = 32'hCAFE_0001; push2(1, 1);
    step(); wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; push2(1, 1);
    step(); m0_cyc = 1'b1; m0_stb = 1'b1; push2(0, 0);
    // Second tie: round-robin alternates to m1, fixed priority keeps m0.
    step(); push2(2, 1);
    step(); wb_ack = 1'b1; wb_dat = 32'hDEAD_BEEF; m1_cyc = 1'b0; m1_stb = 1'b0; push2(2, 1);
    step(); wb_ack = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0;
    push2(0, 1);
    step(); push2(2, 0);
    // Fixed priority serves m1 only while m0 is idle; no preemption once owned.
    step(); m0_cyc = 1'b1; m0_stb = 1'b1; push2(2, 2);
    step(); m1_cyc = 1'b0; m1_stb = 1'b0; push2(2, 2);
    step(); m1_cyc = 1'b1; m1_stb = 1'b1; push2(0, 0);
    step(); push2(1, 1);

`ifdef SD_WB_ARB_TIMEOUT_EN
    for (int k = 0; k < 7; k++) begin
      step(); push2(1, 1);
    end
    step(); push(1'b0, 1, 1'b0, 1'b1); push(1'b1, 1, 1'b0, 1'b1);
    step(); push(1'b0, 1, 1'b1, 1'b0); push(1'b1, 1, 1'b1, 1'b0);
    step(); m0_cyc = 1'b0; m0_stb = 1'b0;
    push(1'b0, 1, 1'b1, 1'b0); push(1'b1, 1, 1'b1, 1'b0);
    step(); push2(0, 0);
    step(); push2(2, 2);
`else
    // Without the watchdog a stalled cycle is held indefinitely with no error.
    for (int k = 0; k < 12; k++) begin
      step(); push2(1, 1);
    end
    step(); wb_err = 1'b1; push2(1, 1);
    step(); wb_err = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; push2(1, 1);
    step(); push2(0, 0);
    step(); push2(2, 2);
`endif

    step(); m1_cyc = 1'b0; m1_stb = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
